dmem_line_responder: RTL
========================

// Module: dmem_line_responder
// PURPOSE
//  Memory-side responder for the 256-bit line-transfer interface driven by the L1 data cache.
//  Accepts one read or write line request at a time and models main-memory access latency.
//  Completes each request with a single-cycle ack. Sits below the data cache, outside the CPU pipeline.
// PARAMETERS
//  LINE_W   256  line width in bits; the low log2(LINE_W/8) address bits are the byte offset and are ignored
//  ADDR_W   32   request address width
//  DEPTH    512  number of lines stored; power of two
//  LATENCY  10   cycles from request accept to ack, inclusive of the ack cycle; legal range >= 2
// PORTS
//  clk       in   1       clock; all state updates on the rising edge
//  rst_n     in   1       asynchronous active-low reset
//  enable_i  in   1       request valid; initiator holds it high until it sees ack_o
//  write_i   in   1       1 = write line, 0 = read line; sampled at accept
//  addr_i    in   ADDR_W  byte address of the line; sampled at accept
//  data_i    in   LINE_W  write data; sampled at accept
//  ack_o     out  1       one-cycle completion pulse
//  data_o    out  LINE_W  read data; valid in the ack cycle of a read and held until the next read ack
//  busy_o    out  1       high from the cycle after accept through the ack cycle
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE, cnt 0, ack_o 0, data_o 0, busy_o 0.
//    Array contents are not reset. Reset during BUSY aborts the request; a pending write is not committed.
//  - FSM IDLE -> BUSY -> ACK -> IDLE.
//  - IDLE: if enable_i is high, capture write_i/addr_i/data_i, load cnt = LATENCY-2, go to BUSY.
//  - BUSY: cnt decrements each cycle; at cnt==0, go to ACK.
//  - ACK: ack_o=1 for exactly this cycle.
//    - Write: line committed at this cycle's edge.
//    - Read: data_o = array[idx] registered into this cycle.
//  - Net latency: accept at cycle T -> ack_o high in cycle T+LATENCY-1 after the accept edge
//    (ack visible LATENCY cycles after enable_i first seen).
//  - After ACK the FSM returns to IDLE. enable_i still high in that IDLE cycle is treated as a new request.
//    Back-to-back throughput is therefore one request per LATENCY+1 cycles.
//  - Inputs changing while BUSY/ACK are ignored (captured copy used). enable_i dropping mid-request does not cancel it.
//  - Index idx = addr[OFF_W+IDX_W-1:OFF_W], where OFF_W = log2(LINE_W/8) and IDX_W = log2(DEPTH).
//  - Write then read of the same line returns the written data; no read-before-write hazard,
//    because requests are serialized.
//  - The cnt width is the minimal width holding LATENCY-2. LATENCY=2 gives a single BUSY cycle.
// CONFIGURATION
//  DMEM_RANGE_CHECK_EN
//   - Defined: adds output err_o (1 bit, reset 0). If captured addr[ADDR_W-1:OFF_W+IDX_W] != 0,
//     err_o pulses with ack_o, writes are suppressed, and reads return all-zero data_o.
//   - Undefined: no err_o port; upper address bits are ignored and out-of-range addresses alias modulo DEPTH lines.
// STRUCTURE
//  - Shared package dmem_pkg:
//    - state enum (IDLE, BUSY, ACK)
//    - OFF_W, IDX_W, LINE_BYTES derivation constants
//    - request struct {write, addr, data}
//  - Sub-module dmem_line_array: DEPTH x LINE_W storage with a synchronous write port and a registered read port.
//  - FSM, latency counter, request capture and range check stay in the top.
// TESTING
//  1. Reset mid-write: rst_n low in BUSY of a write to 0x40, then read 0x40
//     -> previous contents returned; no ack seen before the reset.
//  2. Single write/read: write 0x0000_0020 with data {8{32'hDEAD_BEEF}}, then read 0x20
//     -> each ack arrives LATENCY cycles after enable_i rises; read data_o == written data.
//  3. Offset ignore: write 0x40, read 0x5F -> same line returned.
//     data_o holds that value across a following write ack.
//  4. Back-to-back: enable_i held high across 3 reads -> acks spaced LATENCY+1 cycles apart; exactly 3 ack pulses.
//  5. Input churn: toggle addr_i, data_i and write_i every cycle while BUSY -> the originally captured request completes.
//  6. Range check, with the macro defined: write to 0x0001_0000 with DEPTH=512 -> err_o=1 with ack_o, line 0 unchanged.
//     With the macro undefined, the same write aliases to line 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory line responder: geometry constants,
// FSM state encoding, captured request layout and the line-index helper.
package dmem_pkg;

  localparam int LINE_W     = 256;
  localparam int ADDR_W     = 32;
  localparam int DEPTH      = 512;
  localparam int LINE_BYTES = LINE_W / 8;
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int IDX_W      = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } req_t;

  // Line index: byte offset bits dropped, upper bits above the array ignored.
  function automatic logic [IDX_W-1:0] line_idx(input logic [ADDR_W-1:0] addr);
    return addr[OFF_W+IDX_W-1:OFF_W];
  endfunction

endpackage

// File: rtl/dmem_line_array.sv
// DEPTH x LINE_W line storage. Synchronous write port; registered read port
// whose output holds its value until the next read (or clear) is requested.
// Storage contents are not reset; only the read register is.
module dmem_line_array
  import dmem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx,
  input  logic              we,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_clr,
  output logic [LINE_W-1:0] rd_data
);

  logic [LINE_W-1:0] mem [DEPTH];

  // Commit a line on the write strobe.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wr_data;
    end
  end

  // Read register: clear wins over a load, otherwise hold the last read line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= {LINE_W{1'b0}};
    end else if (rd_clr) begin
      rd_data <= {LINE_W{1'b0}};
    end else if (rd_en) begin
      rd_data <= mem[idx];
    end else begin
      rd_data <= rd_data;
    end
  end

endmodule

// File: rtl/dmem_line_responder.sv
// Memory-side responder for the L1 data-cache line interface. Serializes one
// read/write line request at a time, models a fixed access latency and ends
// each request with a one-cycle ack.
// Optional feature: define DMEM_RANGE_CHECK_EN to add err_o and reject
// addresses whose bits above the line index are non-zero.
module dmem_line_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY = 10  // accept-to-ack cycles including the ack cycle; >= 2
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic              err_o
`endif
);

  // Minimal counter width that still holds LATENCY-2 (at least one bit).
  localparam int              CNT_W    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  req_t              req;
  logic              err;
  logic [IDX_W-1:0]  idx;
  logic              range_err;
  logic              last_busy;
  logic              mem_we;
  logic              mem_rd_en;
  logic              mem_rd_clr;
  logic              unused_addr_lo;

  assign idx            = line_idx(req.addr);
  assign unused_addr_lo = ^req.addr[OFF_W-1:0];

`ifdef DMEM_RANGE_CHECK_EN
  assign range_err = |req.addr[ADDR_W-1:OFF_W+IDX_W];
  assign err_o     = err;
`else
  // Upper address bits are dropped, so out-of-range lines alias modulo DEPTH.
  logic unused_range;
  assign range_err    = 1'b0;
  assign unused_range = ^{req.addr[ADDR_W-1:OFF_W+IDX_W], err};
`endif

  // The read is launched in the final BUSY cycle so data_o lands in the ack cycle;
  // the write is committed at the edge that closes the ack cycle.
  assign last_busy  = (state == BUSY) && (cnt == {CNT_W{1'b0}});
  assign mem_we     = (state == ACK) && req.write && !range_err;
  assign mem_rd_en  = last_busy && !req.write;
  assign mem_rd_clr = last_busy && !req.write && range_err;

  // Request FSM: capture on accept, count down the latency, pulse ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= {CNT_W{1'b0}};
      req    <= '0;
      ack_o  <= 1'b0;
      busy_o <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack_o <= 1'b0;
          err   <= 1'b0;
          if (enable_i) begin
            req.write <= write_i;
            req.addr  <= addr_i;
            req.data  <= data_i;
            cnt       <= CNT_LOAD;
            busy_o    <= 1'b1;
            state     <= BUSY;
          end else begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        BUSY: begin
          if (cnt == {CNT_W{1'b0}}) begin
            ack_o <= 1'b1;
            err   <= range_err;
            state <= ACK;
          end else begin
            cnt   <= cnt - 1'b1;
            state <= BUSY;
          end
        end
        ACK: begin
          ack_o  <= 1'b0;
          busy_o <= 1'b0;
          err    <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          ack_o  <= 1'b0;
          busy_o <= 1'b0;
          err    <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  dmem_line_array u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .idx     (idx),
    .we      (mem_we),
    .wr_data (req.data),
    .rd_en   (mem_rd_en),
    .rd_clr  (mem_rd_clr),
    .rd_data (data_o)
  );

endmodule
